// File: rtl/switch_input_ctrl.sv
// -----------------------------------------------------------------------------
// switch_input_ctrl
//
// Avalon-MM slave for the slide-switch input port. The raw switch lines are
// synchronised through two flops and debounced per bit. Rising edges of the
// debounced value are captured in a write-1-to-clear register. A registered,
// maskable level interrupt is raised towards the CPU.
//
// Register map (read, 1-clock latency, upper bits zero):
//   0 : debounced switch state (stable_q)
//   1 : raw synchronised switch state (s2_q), read-only
//   2 : interrupt mask (mask_q), read/write
//   3 : captured rising edges (edge_q), write 1 to clear
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset, clears all state
//   address     register select
//   chipselect  slave select for writes
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   in_port     raw asynchronous switch lines
//   readdata    registered read data
//   irq         registered level interrupt
//
// WIDTH must be below 32. CNT_W must be wide enough to hold DEBOUNCE_CYCLES-1.
// -----------------------------------------------------------------------------
module switch_input_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;

    // Only the low WIDTH bits of writedata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];

    assign wr_en = chipselect && !write_n;

    always_comb begin
        s1_d = in_port;
        s2_d = s1_q;
    end

    // Per-bit debounce: any sample that matches the accepted value restarts
    // the count, so only an uninterrupted run of DEBOUNCE_CYCLES mismatching
    // samples moves stable_q.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Rising edges are detected on the accepted value as it is updated, so the
    // edge bit sets on the same clock as stable_q. A new edge takes priority
    // over a simultaneous clear so no event is lost.
    always_comb begin
        rise   = stable_d & ~stable_q;
        w1c    = '0;
        mask_d = mask_q;
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            w1c = writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~w1c) | rise;
        irq_d  = |(edge_q & mask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd1:    readdata_d[WIDTH-1:0] = s2_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            default: readdata_d[WIDTH-1:0] = edge_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stable_q   <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_switch_input_ctrl
//
// Directed bench for switch_input_ctrl with WIDTH=8, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; the following rising edge is
// edge 0 of that change. Outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_switch_input_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks;
    int n_errors;

    switch_input_ctrl #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    logic [31:0] r;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        address    = 2'd1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;

        // 1. Reset and read-back
        tick();
        check_eq("rst_rdata_a", readdata, 32'h0);
        check_eq("rst_irq_a", {31'b0, irq}, 32'h0);
        tick();
        check_eq("rst_rdata_b", readdata, 32'h0);
        check_eq("rst_irq_b", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        ticks(2);
        check_eq("sync_a1_e1", readdata, 32'h0);
        tick();
        check_eq("sync_a1_e2", readdata, 32'hFF);

        reset_n = 1'b0;
        address = 2'd0;
        ticks(2);
        check_eq("rst2_rdata", readdata, 32'h0);
        reset_n = 1'b1;
        ticks(6);
        check_eq("stable_a0_e5", readdata, 32'h0);
        tick();
        check_eq("stable_a0_e6", readdata, 32'hFF);
        rd(2'd3, r);
        check_eq("edge_all_rise", r, 32'hFF);
        check_eq("irq_unmasked", {31'b0, irq}, 32'h0);
        wr(2'd3, 32'hFF);
        rd(2'd3, r);
        check_eq("edge_w1c_all", r, 32'h0);

        // 2. Glitch rejection
        in_port = 8'h00;
        ticks(10);
        rd(2'd0, r);
        check_eq("stable_fall", r, 32'h0);
        rd(2'd3, r);
        check_eq("edge_fall_none", r, 32'h0);
        in_port = 8'h01;
        ticks(3);
        in_port = 8'h00;
        ticks(10);
        rd(2'd0, r);
        check_eq("glitch_stable", r, 32'h0);
        rd(2'd3, r);
        check_eq("glitch_edge", r, 32'h0);

        address = 2'd0;
        in_port = 8'h01;
        ticks(6);
        check_eq("pulse_e5_pre", readdata, 32'h0);
        tick();
        check_eq("pulse_e5_post", readdata, 32'h01);
        rd(2'd3, r);
        check_eq("pulse_edge", r, 32'h01);
        wr(2'd3, 32'h01);
        in_port = 8'h00;
        ticks(10);
        rd(2'd3, r);
        check_eq("pulse_cleared", r, 32'h0);

        // 3. Interrupt
        wr(2'd2, 32'h01);
        address = 2'd3;
        in_port = 8'h01;
        ticks(6);
        check_eq("irq_e5", {31'b0, irq}, 32'h0);
        tick();
        check_eq("irq_e6", {31'b0, irq}, 32'h1);
        check_eq("edge_e5", readdata, 32'h01);
        wr(2'd3, 32'h01);
        check_eq("irq_at_w1c", {31'b0, irq}, 32'h1);
        tick();
        check_eq("irq_after_w1c", {31'b0, irq}, 32'h0);
        check_eq("edge_after_w1c", readdata, 32'h0);

        // 4. Masking and falling edge
        wr(2'd2, 32'h00);
        in_port = 8'h09;
        ticks(10);
        rd(2'd3, r);
        check_eq("mask0_edge", r, 32'h08);
        check_eq("mask0_irq", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h08);
        check_eq("mask_wr_irq_same", {31'b0, irq}, 32'h0);
        tick();
        check_eq("mask_wr_irq_next", {31'b0, irq}, 32'h1);
        in_port = 8'h01;
        ticks(10);
        rd(2'd3, r);
        check_eq("fall_no_edge", r, 32'h08);
        rd(2'd0, r);
        check_eq("fall_stable", r, 32'h01);
        wr(2'd3, 32'h08);
        tick();
        check_eq("irq_clear4", {31'b0, irq}, 32'h0);

        // 5. W1C/set collision and ignored writes
        in_port = 8'h05;
        ticks(5);
        wr(2'd3, 32'h04);
        rd(2'd3, r);
        check_eq("collide_set_wins", r, 32'h04);
        rd(2'd0, r);
        check_eq("collide_stable", r, 32'h05);
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'h0000_00AA);
        rd(2'd0, r);
        check_eq("ro_a0", r, 32'h05);
        rd(2'd1, r);
        check_eq("ro_a1", r, 32'h05);
        rd(2'd2, r);
        check_eq("ro_mask", r, 32'h08);
        rd(2'd3, r);
        check_eq("ro_edge", r, 32'h04);
        check_eq("collide_irq", {31'b0, irq}, 32'h0);
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, r);
        check_eq("mask_upper_zero", r, 32'hFF);

        // 6. Reset mid-debounce
        in_port = 8'h25;
        address = 2'd0;
        ticks(3);
        reset_n = 1'b0;
        tick();
        check_eq("mid_rst_rdata", readdata, 32'h0);
        check_eq("mid_rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        ticks(6);
        check_eq("mid_rst_e5_pre", readdata, 32'h0);
        tick();
        check_eq("mid_rst_e5_post", readdata, 32'h25);
        rd(2'd2, r);
        check_eq("mid_rst_mask", r, 32'h0);
        rd(2'd3, r);
        check_eq("mid_rst_edge", r, 32'h25);
        rd(2'd1, r);
        check_eq("mid_rst_s2", r, 32'h25);
        check_eq("mid_rst_irq2", {31'b0, irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_input_ctrl.md
Name: switch_input_ctrl

Overview:
- Avalon-MM slave controller for the 8-bit slide-switch input port on the MicroP system bus.
- Synchronises and debounces the raw switch lines.
- Captures rising edges into a write-1-to-clear register and raises a maskable interrupt to the Nios II CPU.
- Sits between the board switch pins and the system interconnect. It supersedes the bare switch PIO read path.

Parameters:
- WIDTH, 8, number of switch lines.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before a bit is accepted (≥2).
- CNT_W, 5, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select for writes.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits [WIDTH-1:0] used.
- in_port  input  WIDTH  raw asynchronous switch lines.
- readdata  output  32  registered read data.
- irq  output  1  registered level interrupt.

Behaviour:
- Reset: all state clears on the first clk edge with reset_n=0. This covers sync stages, stable_q, debounce counters, mask_q, edge_q, readdata and irq, all going to 0. Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per bit, in_port -> s1 -> s2.
- Debounce (per bit i, independent counter cnt[i]):
  - if s2[i]==stable_q[i]: cnt[i]<=0.
  - else if cnt[i]==DEBOUNCE_CYCLES-1: stable_q[i]<=s2[i], cnt[i]<=0.
  - else: cnt[i]<=cnt[i]+1.
- Debounce latency: in_port changes before edge 0 and is held. stable_q updates at edge DEBOUNCE_CYCLES+1.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES s2 samples never changes stable_q. Any return to match resets the count.
- Edge capture: edge_q[i] sets at the same edge stable_q[i] goes 0->1. Falling transitions are ignored.
- Register map (read):
  - 0 = stable_q.
  - 1 = s2 (raw synchronised, read-only).
  - 2 = mask_q.
  - 3 = edge_q.
  - Upper bits of readdata are zero.
- Read timing: readdata<=mux(address) on every clk edge, with no read strobe. Read latency is 1 clock.
- Writes occur when chipselect=1 and write_n=0:
  - address 2: mask_q<=writedata[WIDTH-1:0].
  - address 3: edge_q[i] cleared where writedata[i]=1 (W1C).
  - addresses 0 and 1: ignored.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, so the bit stays 1.
- irq<=|(edge_q & mask_q), registered. irq asserts one edge after edge_q/mask_q qualify and deasserts one edge after they stop qualifying.
- Mask write and edge set in the same cycle: both take effect at that edge, and irq follows one edge later.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8):
1. Reset and read-back:
   - Stimulus: hold reset_n=0 for 2 edges, with in_port=0xFF throughout. Release, then read address 0 each cycle.
   - Required: readdata=0 and irq=0 during reset. Address 0 reads 0xFF from the read issued after edge 5 post-release.
   - Required: address 1 reads 0xFF from edge 2.
2. Glitch rejection:
   - Stimulus: in_port 0x00 -> 0x01 for 3 cycles, then back to 0x00.
   - Required: stable_q stays 0x00 and edge_q stays 0x00.
   - Stimulus: repeat with a pulse held 4+ cycles.
   - Required: stable_q=0x01 at edge 5 after the change, edge_q=0x01.
3. Interrupt:
   - Stimulus: write mask=0x01 at address 2, then raise bit 0 and hold.
   - Required: edge_q[0] sets at edge 5, irq=1 at edge 6.
   - Stimulus: write 0x01 to address 3.
   - Required: edge_q=0 after that edge, irq=0 one edge later.
4. Masking and falling edge:
   - Stimulus: mask=0x00 with bit 3 rising.
   - Required: edge_q=0x08, irq stays 0.
   - Stimulus: write mask=0x08.
   - Required: irq=1 one edge after the write.
   - Stimulus: bit 3 falling.
   - Required: no new edge_q bit.
5. W1C/set collision:
   - Stimulus: time a W1C of bit 2 at address 3 to coincide with the edge where stable_q[2] rises.
   - Required: edge_q[2]=1 afterwards.
   - Stimulus: writes to addresses 0 and 1.
   - Required: no register change.
6. Reset mid-debounce:
   - Stimulus: bit 5 rises, reset_n=0 at edge 3 for 1 cycle, in_port held.
   - Required: cnt cleared; stable_q[5] rises at edge 5 after release.
   - Required: reads of unmapped upper bits are always 0.
